// File: rtl/l2_arbiter.sv
// Two-port arbiter in front of the L2 L1-side port: picks a requester, latches its
// command, holds it on L2 until hit or timeout, then pulses ack/err/rdata back.
module l2_arbiter #(
  parameter int N            = 32,
  parameter int WORDSPERLINE = 2,
  parameter int FIXED_PRIO   = 0,
  parameter int TIMEOUT      = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      p0_req,
  input  logic                      p0_we,
  input  logic [N-1:0]              p0_addr,
  input  logic [WORDSPERLINE*N-1:0] p0_wdata,
  output logic                      p0_ack,
  output logic                      p0_err,
  output logic [WORDSPERLINE*N-1:0] p0_rdata,
  input  logic                      p1_req,
  input  logic                      p1_we,
  input  logic [N-1:0]              p1_addr,
  input  logic [WORDSPERLINE*N-1:0] p1_wdata,
  output logic                      p1_ack,
  output logic                      p1_err,
  output logic [WORDSPERLINE*N-1:0] p1_rdata,
  output logic [N-1:0]              l2_addr,
  output logic [WORDSPERLINE*N-1:0] l2_data_in,
  output logic                      l2_re,
  output logic                      l2_we,
  input  logic [WORDSPERLINE*N-1:0] l2_data_out,
  input  logic                      l2_hit,
  output logic                      grant_id,
  output logic                      busy,
  output logic                      timeout_flag,
  input  logic                      err_clr
);

  // state   | meaning
  // IDLE    | no owner; arbitrate and latch the winner's command
  // GNT     | latched command driven to L2, waiting for hit or timeout
  // RELEASE | one cycle with L2 port deasserted; ack pulse visible
  typedef enum logic [1:0] {IDLE, GNT, RELEASE} state_t;

  localparam int LW = WORDSPERLINE * N;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic          last_grant;
  logic          winner;
  logic          cmd_we;
  logic [N-1:0]  cmd_addr;
  logic [LW-1:0] cmd_wdata;
  logic [CW-1:0] cnt;
  logic [LW-1:0] hit_rdata;

  always_comb begin
    winner = 1'b0;
    if (p0_req && p1_req) begin
      winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    end else if (p1_req) begin
      winner = 1'b1;
    end
  end

  // writes return an all-zero line even though L2 is read-enabled
  assign hit_rdata = cmd_we ? '0 : l2_data_out;

  assign l2_re      = (state == GNT);
  assign l2_we      = l2_re & cmd_we;
  assign l2_addr    = l2_re ? cmd_addr : '0;
  assign l2_data_in = l2_re ? cmd_wdata : '0;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      grant_id     <= 1'b0;
      cmd_we       <= 1'b0;
      cmd_addr     <= '0;
      cmd_wdata    <= '0;
      cnt          <= '0;
      p0_ack       <= 1'b0;
      p0_err       <= 1'b0;
      p0_rdata     <= '0;
      p1_ack       <= 1'b0;
      p1_err       <= 1'b0;
      p1_rdata     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      p0_ack   <= 1'b0;
      p0_err   <= 1'b0;
      p0_rdata <= '0;
      p1_ack   <= 1'b0;
      p1_err   <= 1'b0;
      p1_rdata <= '0;
      if (err_clr) timeout_flag <= 1'b0;

      case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            state      <= GNT;
            grant_id   <= winner;
            last_grant <= winner;
            cmd_we     <= winner ? p1_we : p0_we;
            cmd_addr   <= winner ? p1_addr : p0_addr;
            cmd_wdata  <= winner ? p1_wdata : p0_wdata;
            cnt        <= '0;
          end
        end
        GNT: begin
          if (l2_hit) begin
            state <= RELEASE;
            if (grant_id) begin
              p1_ack   <= 1'b1;
              p1_rdata <= hit_rdata;
            end else begin
              p0_ack   <= 1'b1;
              p0_rdata <= hit_rdata;
            end
          end else if (cnt == CNT_LAST) begin
            // set outranks a same-cycle err_clr
            state        <= RELEASE;
            timeout_flag <= 1'b1;
            if (grant_id) begin
              p1_ack <= 1'b1;
              p1_err <= 1'b1;
            end else begin
              p0_ack <= 1'b1;
              p0_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          state    <= IDLE;
          grant_id <= 1'b0;
          cnt      <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed plus randomized checks of l2_arbiter against a transaction-level model
// of arbitration order, ack timing, returned data and the sticky timeout flag.
module tb_l2_arbiter;
  localparam int N  = 32;
  localparam int LW = 64;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [N-1:0]  p0_addr = '0, p1_addr = '0;
  logic [LW-1:0] p0_wdata = '0, p1_wdata = '0, l2_data_out = '0;
  logic          l2_hit = 1'b0, err_clr = 1'b0;

  logic          p0_ack, p0_err, p1_ack, p1_err, l2_re, l2_we, grant_id, busy, timeout_flag;
  logic [LW-1:0] p0_rdata, p1_rdata, l2_data_in;
  logic [N-1:0]  l2_addr;

  logic          f_p0_ack, f_p0_err, f_p1_ack, f_p1_err, f_l2_re, f_l2_we, f_grant_id, f_busy, f_tflag;
  logic [LW-1:0] f_p0_rdata, f_p1_rdata, f_l2_data_in;
  logic [N-1:0]  f_l2_addr;

  int n_chk = 0;
  int n_fail = 0;
  bit last_g = 1'b1;
  bit tf = 1'b0;

  always #5 clk = ~clk;

  l2_arbiter #(.N(N), .WORDSPERLINE(2), .FIXED_PRIO(0), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .l2_addr(l2_addr), .l2_data_in(l2_data_in), .l2_re(l2_re), .l2_we(l2_we),
    .l2_data_out(l2_data_out), .l2_hit(l2_hit),
    .grant_id(grant_id), .busy(busy), .timeout_flag(timeout_flag), .err_clr(err_clr)
  );

  l2_arbiter #(.N(N), .WORDSPERLINE(2), .FIXED_PRIO(1), .TIMEOUT(TO)) dut_fp (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(f_p0_ack), .p0_err(f_p0_err), .p0_rdata(f_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(f_p1_ack), .p1_err(f_p1_err), .p1_rdata(f_p1_rdata),
    .l2_addr(f_l2_addr), .l2_data_in(f_l2_data_in), .l2_re(f_l2_re), .l2_we(f_l2_we),
    .l2_data_out(l2_data_out), .l2_hit(l2_hit),
    .grant_id(f_grant_id), .busy(f_busy), .timeout_flag(f_tflag), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Tie goes to whichever port did not win last time (or port 0 when fixed).
  function automatic bit pick(input bit r0, input bit r1, input bit last, input bit fixed);
    if (r0 && r1) return fixed ? 1'b0 : !last;
    return r1;
  endfunction

  // Starts and ends in an IDLE cycle. hit_at > TO means L2 never hits.
  task automatic txn(input bit r0, input bit r1,
                     input bit w0, input logic [N-1:0] a0, input logic [LW-1:0] d0,
                     input bit w1, input logic [N-1:0] a1, input logic [LW-1:0] d1,
                     input int hit_at, input logic [LW-1:0] rd, input bit clr_last);
    bit w, we_w, to;
    logic [N-1:0] a_w;
    logic [LW-1:0] d_w, exp_rd;
    int last_k;
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    chk("idle_busy", 64'(busy), 64'(1'b0));
    w = pick(r0, r1, last_g, 1'b0);
    last_g = w;
    we_w = w ? w1 : w0;
    a_w  = w ? a1 : a0;
    d_w  = w ? d1 : d0;
    to = (hit_at > TO);
    last_k = to ? TO : hit_at;
    for (int k = 1; k <= last_k; k++) begin
      step();
      if (k == 1) begin
        // requester inputs wander during the grant and must be ignored
        p0_req = 1'($urandom); p1_req = 1'($urandom);
        p0_we = 1'($urandom);  p1_we = 1'($urandom);
        p0_addr = $urandom;    p1_addr = $urandom;
        p0_wdata = {$urandom, $urandom}; p1_wdata = {$urandom, $urandom};
      end
      l2_hit = (k == hit_at);
      l2_data_out = (k == hit_at) ? rd : {$urandom, $urandom};
      err_clr = clr_last && (k == last_k);
      chk("gnt_re", 64'(l2_re), 64'(1'b1));
      chk("gnt_we", 64'(l2_we), 64'(we_w));
      chk("gnt_addr", 64'(l2_addr), 64'(a_w));
      chk("gnt_data_in", l2_data_in, d_w);
      chk("gnt_grant_id", 64'(grant_id), 64'(w));
      chk("gnt_no_ack", 64'({p1_ack, p0_ack}), 64'(2'b00));
      chk("gnt_tflag", 64'(timeout_flag), 64'(tf));
    end
    step();
    l2_hit = 1'b0; err_clr = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
    if (to) tf = 1'b1;
    else if (clr_last) tf = 1'b0;
    exp_rd = (to || we_w) ? '0 : rd;
    chk("rel_ack", 64'({p1_ack, p0_ack}), w ? 64'(2'b10) : 64'(2'b01));
    chk("rel_err", 64'(w ? p1_err : p0_err), 64'(to));
    chk("rel_rdata", w ? p1_rdata : p0_rdata, exp_rd);
    chk("rel_other_rdata", w ? p0_rdata : p1_rdata, '0);
    chk("rel_l2_off", 64'({l2_re, l2_we, |l2_addr, |l2_data_in}), 64'(4'b0000));
    chk("rel_busy", 64'(busy), 64'(1'b1));
    chk("rel_tflag", 64'(timeout_flag), 64'(tf));
    step();
    chk("idle_no_ack", 64'({p1_ack, p0_ack, |p0_rdata, |p1_rdata}), 64'(4'b0000));
    chk("idle_state", 64'({busy, grant_id, l2_re}), 64'(3'b000));
  endtask

  initial begin
    step();
    chk("rst_outputs", 64'({p0_ack, p0_err, p1_ack, p1_err, l2_re, l2_we, grant_id, busy, timeout_flag}), 64'(9'd0));
    chk("rst_data", p0_rdata | p1_rdata | l2_data_in | 64'(l2_addr), '0);
    rst = 1'b1;
    step();

    // Port 0 read hit on the first grant cycle
    txn(1, 0, 0, 32'h0000_0104, '0, 0, '0, '0, 1, 64'hDEAD_BEEF_1234_5678, 0);
    // Port 1 write, hit in the fifth grant cycle, rdata must be zero
    txn(0, 1, 0, '0, '0, 1, 32'h0000_0200, 64'hA5A5_A5A5_5A5A_5A5A, 5, 64'hFFFF_0000_FFFF_0000, 0);
    // Both request: port 0 wins since port 1 was last
    txn(1, 1, 0, 32'h0000_0300, '0, 1, 32'h0000_0400, 64'h1, 3, 64'h0BAD_F00D_CAFE_0001, 0);
    // Timeout, then clear in IDLE, then timeout with simultaneous clear
    txn(1, 0, 0, 32'h0000_0500, '0, 0, '0, '0, 99, 64'h5, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    tf = 1'b0;
    chk("clr_flag", 64'(timeout_flag), 64'(1'b0));
    txn(0, 1, 1, '0, '0, 0, 32'h0000_0600, '0, 99, 64'h6, 1);
    // Hit on the timeout cycle itself: hit wins
    txn(1, 0, 0, 32'h0000_0700, '0, 0, '0, '0, TO, 64'h7777_0000_8888_0000, 0);
    // Clearing on a hit-terminated transaction
    txn(1, 1, 0, 32'h0000_0800, '0, 0, 32'h0000_0900, '0, 2, 64'h99, 1);

    // Reset in the middle of a grant
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0000_0A00;
    step();
    step();
    chk("pre_rst_re", 64'(l2_re), 64'(1'b1));
    rst = 1'b0;
    #1;
    chk("mid_rst_outputs", 64'({p0_ack, p1_ack, l2_re, l2_we, grant_id, busy, timeout_flag}), 64'(7'd0));
    chk("mid_rst_addr", 64'(l2_addr), 64'(0));
    last_g = 1'b1;
    tf = 1'b0;
    p1_req = 1'b1;
    step();
    chk("rst_no_ack", 64'({p0_ack, p1_ack}), 64'(2'b00));
    rst = 1'b1;
    txn(1, 1, 0, 32'h0000_0B00, '0, 0, 32'h0000_0C00, '0, 1, 64'hB0B0, 0);

    // Continuous requests: round-robin alternates, fixed priority always picks 0
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      p0_req = 1'b1; p1_req = 1'b1; p0_we = 1'b0; p1_we = 1'b0;
      p0_addr = $urandom; p1_addr = $urandom;
      step();
      chk("rr_grant", 64'(grant_id), 64'(i % 2));
      chk("fp_grant", 64'(f_grant_id), 64'(1'b0));
      chk("fp_re", 64'(f_l2_re), 64'(1'b1));
      l2_hit = 1'b1;
      step();
      l2_hit = 1'b0;
      chk("rr_ack", 64'({p1_ack, p0_ack}), (i % 2 == 1) ? 64'(2'b10) : 64'(2'b01));
      chk("fp_ack", 64'({f_p1_ack, f_p0_ack}), 64'(2'b01));
      step();
    end
    p0_req = 1'b0; p1_req = 1'b0;
    last_g = 1'b1;
    tf = 1'b0;
    step();

    // Randomized transactions against the model
    for (int i = 0; i < 24; i++) begin
      bit r0, r1;
      r0 = 1'($urandom);
      r1 = r0 ? 1'($urandom) : 1'b1;
      txn(r0, r1, 1'($urandom), $urandom, {$urandom, $urandom},
          1'($urandom), $urandom, {$urandom, $urandom},
          int'($urandom_range(1, 10)), {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
